// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and FSM state encodings
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;

    // IDLE..STOP encodings are common with the transmitter FSM
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter with mid-bit and end-of-period ticks
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic mid_tick,
    output logic sample_tick
);

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] MID  = 8'((CLKS_PER_BIT - 1) / 2);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

    assign mid_tick    = (count == MID);
    assign sample_tick = (count == LAST);

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8E1 UART receiver, MSB first, with parity and framing checks
module uart_receiver #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       rx_busy,
    output logic       rx_done,
    output logic       parity_err,
    output logic       frame_err
);
    import uart_pkg::*;

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    logic        sync_meta, sync_line, line_d;
    uart_state_t state, state_next;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;
    logic        parity_bad;
    logic        timer_clear, mid_tick, sample_tick, bit_sample;

    // line_d lags the detector by one cycle so the start-bit sample stays
    // inside the start bit even when a bit lasts a single clock
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= LINE_IDLE;
            sync_line <= LINE_IDLE;
            line_d    <= LINE_IDLE;
        end else begin
            sync_meta <= data_in;
            sync_line <= sync_meta;
            line_d    <= sync_line;
        end
    end

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (timer_clear),
        .mid_tick    (mid_tick),
        .sample_tick (sample_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        timer_clear = 1'b0;
        bit_sample  = 1'b0;
        case (state)
            IDLE: begin
                timer_clear = 1'b1;
                if (!sync_line) state_next = START;
            end
            START: begin
                if (mid_tick) begin
                    timer_clear = 1'b1;
                    bit_sample  = 1'b1;
                    state_next  = line_d ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_tick) begin
                    bit_sample = 1'b1;
                    if (bit_cnt == LAST_BIT) state_next = PARITY;
                end
            end
            PARITY: begin
                if (sample_tick) begin
                    bit_sample = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                // a start edge already on the line is taken directly so zero-gap frames survive
                if (sample_tick) begin
                    bit_sample  = 1'b1;
                    timer_clear = 1'b1;
                    if (!line_d)         state_next = WAIT_HIGH;
                    else if (!sync_line) state_next = START;
                    else                 state_next = IDLE;
                end
            end
            WAIT_HIGH: begin
                timer_clear = 1'b1;
                if (sync_line) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bad <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            rx_done    <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (bit_sample) begin
                case (state)
                    DATA: begin
                        shift   <= {shift[6:0], line_d};
                        bit_cnt <= (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
                    end
                    PARITY: parity_bad <= line_d ^ (^shift);
                    STOP: begin
                        data_out   <= shift;
                        parity_err <= parity_bad;
                        frame_err  <= ~line_d;
                        rx_done    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized frame-level bench for uart_receiver at 1 and 16 clocks per bit
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       line1, line16;
    logic [7:0] dout1, dout16;
    logic       busy1, busy16, done1, done16, pe1, pe16, fe1, fe16;

    always #5 clk = ~clk;

    uart_receiver #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(line1), .data_out(dout1), .rx_busy(busy1),
        .rx_done(done1), .parity_err(pe1), .frame_err(fe1)
    );

    uart_receiver #(.CLKS_PER_BIT(16)) dut16 (
        .clk(clk), .rst(rst), .data_in(line16), .data_out(dout16), .rx_busy(busy16),
        .rx_done(done16), .parity_err(pe16), .frame_err(fe16)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int chk1  = 0;
    int chk16 = 0;
    logic prev1 = 1'b0;
    logic prev16 = 1'b0;

    logic [9:0] rcv1_q[$], rcv16_q[$], exp1_q[$], exp16_q[$];
    int         stamp1_q[$], stamp16_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level model: decoded byte, parity mismatch against even parity, stop bit low
    function automatic logic [9:0] expect_frame(input logic [7:0] b, input logic par, input logic stop);
        return {b, par != (^b), ~stop};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done1) begin
            check("done1_width", 32'(prev1), 32'd0);
            rcv1_q.push_back({dout1, pe1, fe1});
            stamp1_q.push_back(cyc);
        end
        if (done16) begin
            check("done16_width", 32'(prev16), 32'd0);
            rcv16_q.push_back({dout16, pe16, fe16});
            stamp16_q.push_back(cyc);
        end
        prev1  = done1;
        prev16 = done16;
    end

    task automatic drive(input int which, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (which == 1) line1 = v;
            else            line16 = v;
        end
    endtask

    // which doubles as the bit period in clocks (1 or 16)
    task automatic send_frame(input int which, input logic [7:0] b, input logic par, input logic stop);
        logic [10:0] bits;
        bits = {1'b0, b, par, stop};
        for (int i = 10; i >= 0; i--) drive(which, bits[i], which);
        if (which == 1) exp1_q.push_back(expect_frame(b, par, stop));
        else            exp16_q.push_back(expect_frame(b, par, stop));
    endtask

    task automatic drain(input int which);
        int budget;
        budget = 0;
        while (budget < 400 &&
               ((which == 1) ? (rcv1_q.size() < exp1_q.size()) : (rcv16_q.size() < exp16_q.size()))) begin
            @(negedge clk);
            budget++;
        end
        repeat (3) @(negedge clk);
        if (which == 1) begin
            check("frame_count1", 32'(rcv1_q.size()), 32'(exp1_q.size()));
            while (chk1 < exp1_q.size() && chk1 < rcv1_q.size()) begin
                check($sformatf("frame1_%0d", chk1), 32'(rcv1_q[chk1]), 32'(exp1_q[chk1]));
                chk1++;
            end
        end else begin
            check("frame_count16", 32'(rcv16_q.size()), 32'(exp16_q.size()));
            while (chk16 < exp16_q.size() && chk16 < rcv16_q.size()) begin
                check($sformatf("frame16_%0d", chk16), 32'(rcv16_q[chk16]), 32'(exp16_q[chk16]));
                chk16++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       par, stop;
        int         base;

        rst = 1'b1; line1 = 1'b1; line16 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset1",  32'({dout1, busy1, done1, pe1, fe1}), 32'd0);
        check("reset16", 32'({dout16, busy16, done16, pe16, fe16}), 32'd0);

        drive(1, 1'b1, 3);
        send_frame(1, 8'hA5, 1'b0, 1'b1);
        drive(1, 1'b1, 4);
        drain(1);

        send_frame(16, 8'h3C, 1'b1, 1'b1);
        drive(16, 1'b1, 20);
        drain(16);

        send_frame(16, 8'hFF, 1'b0, 1'b0);
        drive(16, 1'b0, 40);
        @(negedge clk);
        check("wait_high_busy", 32'(busy16), 32'd1);
        drive(16, 1'b1, 6);
        @(negedge clk);
        check("wait_high_exit", 32'(busy16), 32'd0);
        drain(16);

        drive(16, 1'b0, 4);
        drive(16, 1'b1, 40);
        @(negedge clk);
        check("glitch_busy", 32'(busy16), 32'd0);
        check("glitch_hold", 32'({dout16, pe16, fe16}), 32'(exp16_q[$]));
        drain(16);

        for (int w = 1; w <= 16; w += 15) begin
            base = (w == 1) ? stamp1_q.size() : stamp16_q.size();
            b = 8'h01; send_frame(w, b, ^b, 1'b1);
            b = 8'h80; send_frame(w, b, ^b, 1'b1);
            drive(w, 1'b1, 2 * w + 4);
            drain(w);
            if (w == 1 && stamp1_q.size() >= base + 2)
                check("b2b_gap1", 32'(stamp1_q[base + 1] - stamp1_q[base]), 32'd11);
            else if (w == 16 && stamp16_q.size() >= base + 2)
                check("b2b_gap16", 32'(stamp16_q[base + 1] - stamp16_q[base]), 32'd176);
            else
                check("b2b_pulses", 32'((w == 1) ? stamp1_q.size() - base : stamp16_q.size() - base), 32'd2);
        end

        b = 8'h55;
        drive(16, 1'b0, 16);
        drive(16, b[7], 16);
        drive(16, b[6], 16);
        drive(16, b[5], 8);
        @(posedge clk);
        #1 rst = 1'b1; line16 = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid16", 32'({dout16, busy16, done16, pe16, fe16}), 32'd0);
        check("rst_mid1",  32'({dout1, busy1, done1, pe1, fe1}), 32'd0);
        drive(16, 1'b1, 20);
        send_frame(16, b, ^b, 1'b1);
        drive(16, 1'b1, 20);
        drain(16);

        for (int w = 1; w <= 16; w += 15) begin
            for (int i = 0; i < ((w == 1) ? 30 : 10); i++) begin
                b    = 8'($urandom);
                par  = (^b) ^ ($urandom_range(0, 3) == 0);
                stop = ($urandom_range(0, 3) != 0);
                send_frame(w, b, par, stop);
                if (!stop) begin
                    drive(w, 1'b0, $urandom_range(0, 2 * w));
                    drive(w, 1'b1, $urandom_range(3, 3 + w));
                end else begin
                    drive(w, 1'b1, $urandom_range(0, 2 * w));
                end
            end
            drive(w, 1'b1, 3 * w + 5);
            drain(w);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 1, clk cycles per serial bit (1 = one bit per clk, matching uart_transmitter line rate); legal range 1..255.
REQ-002 The block SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port data_in  input  1  serial line, idle high.
REQ-005 The block SHALL have port data_out  output  8  last received data byte.
REQ-006 The block SHALL have port rx_busy  output  1  frame reception in progress.
REQ-007 The block SHALL have port rx_done  output  1  one-cycle pulse, frame complete.
REQ-008 The block SHALL have port parity_err  output  1  parity mismatch on last frame.
REQ-009 The block SHALL have port frame_err  output  1  stop bit sampled low on last frame.

Function
REQ-010 Frame format SHALL be: start bit 0, 8 data bits MSB first, 1 even-parity bit (parity = XOR of the 8 data bits), stop bit 1; 11 bit times total.
REQ-011 data_in SHALL pass through a 2-flop synchronizer (reset value 1) before any use; all sampling uses the synchronized signal.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-013 IDLE: synchronized line low -> START, bit timer cleared, rx_busy set the next cycle.
REQ-014 START: sample at timer = (CLKS_PER_BIT-1)/2 (integer); sample 1 -> false start, back to IDLE with no rx_done; sample 0 -> DATA.
REQ-015 Subsequent samples SHALL occur every CLKS_PER_BIT cycles after the start sample; with CLKS_PER_BIT=1, every cycle.
REQ-016 DATA: 8 samples shifted left into the shift register, new bit into bit 0, so the first received bit lands in bit 7; after 8th sample -> PARITY.
REQ-017 PARITY: one sample, compared with XOR of shift register -> STOP.
REQ-018 STOP: one sample; 1 -> IDLE; 0 -> WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until synchronized line is 1, then -> IDLE; no new start detected while in WAIT_HIGH.
REQ-020 On the stop-bit sample cycle +1, data_out, parity_err and frame_err SHALL update together and rx_done SHALL pulse high exactly one cycle, for both good and errored frames.
REQ-021 data_out, parity_err, frame_err SHALL hold between rx_done pulses.
REQ-022 rx_busy SHALL be high from the cycle after start detection until the FSM re-enters IDLE (WAIT_HIGH counts as busy); low otherwise.
REQ-023 A new start bit immediately following a good stop bit SHALL be detected (back-to-back frames, zero idle gap) with no lost frame.
REQ-024 Bit timer SHALL be 8 bits wide and wrap to 0 at CLKS_PER_BIT-1; bit counter 4 bits, 0..7.

Reset
REQ-025 rst SHALL force FSM to IDLE, timers/counters 0, shift register 0, synchronizer flops 1, data_out 8'h00, rx_busy 0, rx_done 0, parity_err 0, frame_err 0, on the next clk edge, from any state.
REQ-026 rst asserted mid-frame SHALL abort the frame with no rx_done; reception restarts on the next falling edge after rst deasserts.

Structure
REQ-027 FSM state encodings (IDLE..STOP shared with transmitter FSM), DATA_BITS=8 and line idle level SHALL live in shared package uart_pkg.
REQ-028 Bit-period timing SHALL be one sub-module, uart_bit_timer (counter, clear input, mid-bit/sample-tick outputs).

Verification
REQ-029 CLKS_PER_BIT=1, frame for 8'hA5 (parity 0, stop 1) -> data_out=8'hA5, rx_done pulse once, parity_err=0, frame_err=0.
REQ-030 CLKS_PER_BIT=16, 8'h3C with parity bit 1 -> data_out=8'h3C, parity_err=1, frame_err=0.
REQ-031 CLKS_PER_BIT=16, 8'hFF with stop bit 0, line held low 40 cycles -> rx_done once, frame_err=1, rx_busy stays 1 until line high, no second frame.
REQ-032 CLKS_PER_BIT=16, 4-cycle low glitch on idle line -> no rx_done, rx_busy returns 0, outputs unchanged.
REQ-033 Back-to-back 8'h01 then 8'h80, zero gap -> two rx_done pulses 11*CLKS_PER_BIT cycles apart, data_out 8'h01 then 8'h80.
REQ-034 rst pulsed during DATA of 8'h55 -> all outputs to reset values, no rx_done; following 8'h55 frame received correctly.
